// File: rtl/spike_dispatch_pkg.sv
// spike_dispatch_pkg: state encoding and default sizes shared by the spike dispatch queue.
package spike_dispatch_pkg;
   localparam int NEURON_WIDTH_DEF    = 14;
   localparam int QUEUE_DEPTH_LOG_DEF = 6;
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ROUTE = 3'd2,
      GAP   = 3'd3,
      DONE  = 3'd4
   } state_t;
endpackage

// File: rtl/spike_id_fifo.sv
// spike_id_fifo: register-array circular FIFO of neuron IDs with synchronous clear.
// A pop in the same cycle frees a slot, so a push into a full FIFO is accepted alongside it.
module spike_id_fifo
   import spike_dispatch_pkg::*;
#(
   parameter int W = NEURON_WIDTH_DEF,
   parameter int L = QUEUE_DEPTH_LOG_DEF
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         Clear,
   input  logic         Push,
   input  logic         Pop,
   input  logic [W-1:0] PushData,
   output logic [W-1:0] PopData,
   output logic         Full,
   output logic         Empty,
   output logic [L:0]   Count
);
   logic [W-1:0] mem [2**L];
   logic [L-1:0] wr_ptr, rd_ptr;
   logic do_pop, do_push;
   assign Full    = Count[L];
   assign Empty   = Count == '0;
   assign PopData = mem[rd_ptr];
   assign do_pop  = Pop && !Empty && !Clear;
   assign do_push = Push && !Clear && (!Full || do_pop);
   always_ff @(posedge Clock or negedge Reset)
      if (!Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         Count  <= '0;
      end else if (Clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         Count  <= '0;
      end else begin
         wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
         Count  <= (do_push && !do_pop) ? Count + 1'b1 : (do_pop && !do_push) ? Count - 1'b1 : Count;
      end
   always_ff @(posedge Clock)
      if (do_push) mem[wr_ptr] <= PushData;
endmodule

// File: rtl/spike_dispatch_queue.sv
// spike_dispatch_queue: buffers spiked neuron IDs and feeds them one pass at a time to the router.
// Optional SPIKE_DROP_COUNT_EN adds DropCount/DropFlag overflow reporting.
module spike_dispatch_queue
   import spike_dispatch_pkg::*;
#(
   parameter int NEURON_WIDTH    = NEURON_WIDTH_DEF,
   parameter int QUEUE_DEPTH_LOG = QUEUE_DEPTH_LOG_DEF,
   parameter int COUNT_WIDTH     = QUEUE_DEPTH_LOG + 1
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic                    Initialize,
   input  logic                    SpikeValid,
   input  logic [NEURON_WIDTH-1:0] SpikeID,
   output logic                    SpikeReady,
   input  logic                    WaveStart,
   input  logic                    RoutingComplete,
   output logic                    RouteEnable,
   output logic [NEURON_WIDTH-1:0] NeuronID,
   output logic                    WaveDone,
   output logic                    Busy,
`ifdef SPIKE_DROP_COUNT_EN
   output logic [COUNT_WIDTH-1:0]  Count,
   output logic [15:0]             DropCount,
   output logic                    DropFlag
`else
   output logic [COUNT_WIDTH-1:0]  Count
`endif
);
   state_t state, next_state;
   logic clear, pop, full, empty;
   logic [NEURON_WIDTH-1:0] head;
   // The router is mid-pass while RouteEnable is high, so Initialize must not disturb it.
   assign clear       = Initialize && state != ROUTE;
   assign pop         = state == LOAD && !clear;
   assign SpikeReady  = !full || pop;
   assign RouteEnable = state == ROUTE;
   assign Busy        = state != IDLE;
   spike_id_fifo #(.W(NEURON_WIDTH), .L(QUEUE_DEPTH_LOG)) u_fifo (
      .Clock    (Clock),
      .Reset    (Reset),
      .Clear    (clear),
      .Push     (SpikeValid),
      .Pop      (pop),
      .PushData (SpikeID),
      .PopData  (head),
      .Full     (full),
      .Empty    (empty),
      .Count    (Count)
   );
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = WaveStart ? (empty ? DONE : LOAD) : IDLE;
         LOAD:    next_state = ROUTE;
         ROUTE:   next_state = RoutingComplete ? GAP : ROUTE;
         GAP:     next_state = empty ? DONE : LOAD;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (clear) next_state = IDLE;
   end
   // NeuronID is captured on entry to LOAD so it is settled a full cycle before RouteEnable rises.
   always_ff @(posedge Clock or negedge Reset)
      if (!Reset) begin
         state    <= IDLE;
         NeuronID <= '0;
         WaveDone <= 1'b0;
      end else begin
         state    <= next_state;
         NeuronID <= clear ? '0 : (next_state == LOAD) ? head : NeuronID;
         WaveDone <= state == DONE && !clear;
      end
`ifdef SPIKE_DROP_COUNT_EN
   always_ff @(posedge Clock or negedge Reset)
      if (!Reset) begin
         DropCount <= '0;
         DropFlag  <= 1'b0;
      end else if (clear) begin
         DropCount <= '0;
         DropFlag  <= 1'b0;
      end else if (SpikeValid && !SpikeReady) begin
         DropCount <= DropCount + {15'd0, DropCount != 16'hFFFF};
         DropFlag  <= 1'b1;
      end
`endif
endmodule

// File: tb/tb_spike_dispatch_queue.sv
// tb_spike_dispatch_queue: directed scoreboard bench for spike_dispatch_queue.
module tb_spike_dispatch_queue;
   logic Clock = 0, Reset = 0, Initialize = 0, SpikeValid = 0, WaveStart = 0, RoutingComplete = 0;
   logic [13:0] SpikeID = '0;
   logic SpikeReady, RouteEnable, WaveDone, Busy;
   logic [13:0] NeuronID;
   logic [6:0] Count;
`ifdef SPIKE_DROP_COUNT_EN
   logic [15:0] DropCount;
   logic DropFlag;
`endif
   int n_chk = 0, n_fail = 0, done_cnt = 0, rise_cnt = 0, r_cnt = 0, low_cnt = 0;
   bit router_on = 0, fall_valid = 0;
   logic m_prev_re = 0;
   logic [13:0] m_prev_id = '0;
   logic [31:0] m_exp;
   logic [13:0] exp_q[$];
   always #5 Clock = ~Clock;
   spike_dispatch_queue dut (
      .Clock(Clock), .Reset(Reset), .Initialize(Initialize), .SpikeValid(SpikeValid),
      .SpikeID(SpikeID), .SpikeReady(SpikeReady), .WaveStart(WaveStart),
      .RoutingComplete(RoutingComplete), .RouteEnable(RouteEnable), .NeuronID(NeuronID),
      .WaveDone(WaveDone), .Busy(Busy),
`ifdef SPIKE_DROP_COUNT_EN
      .Count(Count), .DropCount(DropCount), .DropFlag(DropFlag)
`else
      .Count(Count)
`endif
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick(input int n = 1);
      repeat (n) @(negedge Clock);
   endtask
   task automatic push(input logic [13:0] id, input bit routed);
      SpikeValid = 1;
      SpikeID = id;
      if (routed) exp_q.push_back(id);
      tick();
      SpikeValid = 0;
   endtask
   task automatic start_wave();
      WaveStart = 1;
      tick();
      WaveStart = 0;
   endtask
   task automatic wait_wave(input int budget);
      int d = done_cnt;
      for (int i = 0; i < budget && done_cnt == d; i++) tick();
      check("wave_done_seen", done_cnt - d, 1);
      tick(3);
      check("wave_done_once", done_cnt - d, 1);
      check("idle_after_wave", Busy, 0);
   endtask
   // Router model: answers each pass with RoutingComplete after 10 cycles of RouteEnable.
   initial forever begin
      @(negedge Clock);
      if (RoutingComplete) RoutingComplete = 0;
      else if (router_on && RouteEnable) begin
         r_cnt++;
         if (r_cnt == 10) begin
            RoutingComplete = 1;
            r_cnt = 0;
         end
      end else r_cnt = 0;
   end
   // Monitor: scoreboard pop on every RouteEnable rise, plus preload and gap-length checks.
   initial forever begin
      @(negedge Clock);
      if (!Reset) fall_valid = 0;
      else if (RouteEnable && !m_prev_re) begin
         rise_cnt++;
         m_exp = exp_q.size() != 0 ? 32'(exp_q.pop_front()) : 'x;
         check("route_id", 32'(NeuronID), m_exp);
         check("id_preload", 32'(m_prev_id), m_exp);
         if (fall_valid) check("gap_len", low_cnt, 2);
      end else if (!RouteEnable && m_prev_re) begin
         fall_valid = 1;
         low_cnt = 1;
      end else if (!RouteEnable) low_cnt++;
      if (WaveDone) begin
         done_cnt++;
         fall_valid = 0;
         check("drained_at_done", exp_q.size(), 0);
      end
      m_prev_re = RouteEnable;
      m_prev_id = NeuronID;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end
   initial begin
      int r;
      tick(2);
      check("rst_route_enable", RouteEnable, 0);
      check("rst_neuron_id", NeuronID, 0);
      check("rst_wave_done", WaveDone, 0);
      check("rst_busy", Busy, 0);
      check("rst_count", Count, 0);
      Reset = 1;
      tick();
      check("ready_after_reset", SpikeReady, 1);
      // Reset in the middle of a routing pass with queued IDs.
      push(11, 1);
      push(12, 0);
      push(13, 0);
      check("count_three", Count, 3);
      start_wave();
      check("load_re_low", RouteEnable, 0);
      check("load_id", NeuronID, 11);
      tick();
      check("first_rise_latency", RouteEnable, 1);
      check("count_after_pop", Count, 2);
      #2 Reset = 0;
      #1;
      check("async_rst_re", RouteEnable, 0);
      check("async_rst_count", Count, 0);
      check("async_rst_busy", Busy, 0);
      check("async_rst_ready", SpikeReady, 1);
      check("async_rst_id", NeuronID, 0);
      tick(2);
      Reset = 1;
      tick();
      // Basic three-ID wave.
      router_on = 1;
      push(5, 1);
      push(2050, 1);
      push(17, 1);
      r = rise_cnt;
      start_wave();
      wait_wave(200);
      check("three_passes", rise_cnt - r, 3);
      // Wave started on an empty queue.
      check("empty_count", Count, 0);
      r = rise_cnt;
      start_wave();
      check("empty_done_early", WaveDone, 0);
      check("empty_busy", Busy, 1);
      tick();
      check("empty_done_pulse", WaveDone, 1);
      tick();
      check("empty_done_end", WaveDone, 0);
      check("empty_no_route", rise_cnt - r, 0);
      // Push during a ROUTE pass joins the same wave.
      push(5, 1);
      push(6, 1);
      start_wave();
      tick();
      check("route_for_late_push", RouteEnable, 1);
      push(7, 1);
      wait_wave(300);
      // Fill to capacity, overflow drop, then a LOAD-cycle push while full.
      router_on = 0;
      for (int i = 0; i < 64; i++) push(14'(100 + i), 1);
      check("count_full", Count, 64);
      check("ready_full", SpikeReady, 0);
      push(99, 0);
      check("count_after_drop", Count, 64);
`ifdef SPIKE_DROP_COUNT_EN
      check("drop_count", DropCount, 1);
      check("drop_flag", DropFlag, 1);
`endif
      router_on = 1;
      start_wave();
      check("load_ready_full", SpikeReady, 1);
      SpikeValid = 1;
      SpikeID = 33;
      exp_q.push_back(33);
      tick();
      SpikeValid = 0;
      check("count_push_pop_full", Count, 64);
      check("route_after_full_load", RouteEnable, 1);
      wait_wave(3000);
      // Initialize during ROUTE is ignored.
      push(40, 1);
      push(41, 1);
      start_wave();
      tick();
      Initialize = 1;
      tick();
      Initialize = 0;
      check("init_route_re", RouteEnable, 1);
      check("init_route_count", Count, 1);
      check("init_route_busy", Busy, 1);
      wait_wave(300);
      // Initialize in IDLE empties the queue and clears NeuronID.
      router_on = 0;
      for (int i = 0; i < 4; i++) push(14'(200 + i), 0);
      check("count_four", Count, 4);
      check("id_held_idle", NeuronID, 41);
      Initialize = 1;
      tick();
      Initialize = 0;
      check("init_idle_count", Count, 0);
      check("init_idle_id", NeuronID, 0);
      check("init_idle_done", WaveDone, 0);
      check("init_idle_busy", Busy, 0);
      check("init_idle_ready", SpikeReady, 1);
`ifdef SPIKE_DROP_COUNT_EN
      check("init_drop_count", DropCount, 0);
      check("init_drop_flag", DropFlag, 0);
`endif
      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/spike_dispatch_queue.md
Name: spike_dispatch_queue

Overview:
- Upstream feeder of the input router.
- Buffers the IDs of spiked neurons (input and logical) in a circular FIFO.
- During a routing wave it pops one ID at a time, presents it on NeuronID and frames a RouteEnable pulse around each routing pass. The next ID is released only after RoutingComplete.
- Reports WaveDone to system control once the queue has drained.

Parameters:
- NEURON_WIDTH, 14, width of a neuron ID.
- QUEUE_DEPTH_LOG, 6, log2 of FIFO depth (default depth 64).
- COUNT_WIDTH, QUEUE_DEPTH_LOG+1, occupancy counter width.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Initialize  in  1  sync clear of FIFO and FSM; ignored while RouteEnable=1.
- SpikeValid  in  1  push request.
- SpikeID  in  NEURON_WIDTH  ID to push.
- SpikeReady  out  1  FIFO not full.
- WaveStart  in  1  one-cycle pulse: begin draining the queue.
- RoutingComplete  in  1  from router, high for one cycle at end of a pass.
- RouteEnable  out  1  to router: routing pass active.
- NeuronID  out  NEURON_WIDTH  to router: ID being routed.
- WaveDone  out  1  one-cycle pulse: queue drained, wave finished.
- Busy  out  1  FSM not in IDLE.
- Count  out  COUNT_WIDTH  current occupancy.

Behaviour:
- Reset (async, Reset=0):
  - RouteEnable=0, NeuronID=0, WaveDone=0, Busy=0, Count=0.
  - Read/write pointers=0, state=IDLE.
  - SpikeReady=1 after reset release.
- FIFO:
  - Push occurs when SpikeValid && SpikeReady.
  - Push while full is dropped; FIFO contents are unchanged.
  - Pop is internal, only in state LOAD.
  - Simultaneous push and pop: both occur, Count unchanged. This holds when full too, because the pop frees a slot in the same cycle and SpikeReady is computed as !full || pop.
  - Pointers wrap modulo 2^QUEUE_DEPTH_LOG.
  - Order is strictly FIFO.
- FSM states: IDLE, LOAD, ROUTE, GAP, DONE.
  - IDLE: on WaveStart, go to LOAD if Count>0, else go to DONE.
  - LOAD: pop the head into the NeuronID register. RouteEnable stays 0. Next state ROUTE.
    - NeuronID is stable at least one full cycle before RouteEnable rises, because the router samples the ID on the RouteEnable rising edge.
  - ROUTE: RouteEnable=1 and NeuronID held constant. On RoutingComplete go to GAP.
  - GAP: RouteEnable=0 for exactly one cycle so the router clears its column counter. Next state is LOAD if Count>0, else DONE.
  - DONE: WaveDone=1 for one cycle. Next state IDLE.
- Spikes pushed during a wave are routed in the same wave; the queue drains until empty.
- WaveStart outside IDLE is ignored.
- RoutingComplete outside ROUTE is ignored.
- NeuronID keeps its last value in IDLE.
- Initialize with RouteEnable=0 (any state other than ROUTE): synchronously empties the FIFO, returns to IDLE, NeuronID=0, no WaveDone.
- Initialize with RouteEnable=1: no effect.
- Reset mid-wave: immediate return to reset values. Queued spikes are lost.
- Latency:
  - WaveStart to first RouteEnable rise: 2 cycles.
  - RoutingComplete to next RouteEnable rise: 3 cycles (GAP, LOAD, ROUTE).

Optional Feature:
- Macro SPIKE_DROP_COUNT_EN.
- When defined:
  - Adds output DropCount [15:0], which increments on each push attempted while full and saturates at 16'hFFFF.
  - Adds output DropFlag, sticky until Reset or Initialize.
  - Both are cleared by Reset and by Initialize.
- When undefined: neither port exists and overflow pushes are silently dropped.

Decomposition:
- Package spike_dispatch_pkg holds:
  - State encoding constants: IDLE=0, LOAD=1, ROUTE=2, GAP=3, DONE=4, in 3 bits.
  - Default NEURON_WIDTH and QUEUE_DEPTH_LOG constants.
- Sub-module spike_id_fifo:
  - Register-array circular FIFO with push/pop/full/empty/count.
  - Same async active-low reset and synchronous clear input.
  - The top level contains only the FSM and output registers.

Test Plan:
- Reset=0 mid-ROUTE with 3 queued IDs -> RouteEnable=0 immediately, Count=0, state IDLE, SpikeReady=1.
- Push IDs 5, 2050, 17, then WaveStart, with RoutingComplete returned 10 cycles after each RouteEnable rise:
  - RouteEnable framed three times with NeuronID 5, 2050, 17 in order.
  - NeuronID is stable one cycle before each rise.
  - RouteEnable is low exactly 1 GAP cycle plus 1 LOAD cycle between passes.
  - WaveDone pulses once.
- WaveStart with empty queue -> no RouteEnable; WaveDone 2 cycles later.
- Fill to 64 entries, then push ID 99 -> SpikeReady=0 and ID 99 is dropped. With SPIKE_DROP_COUNT_EN defined, DropCount=1 and DropFlag=1.
- Push ID 7 during the ROUTE of ID 5 -> ID 7 is routed in the same wave after the existing entries; WaveDone only after ID 7's pass completes.
- Full queue with a LOAD-cycle push of ID 33 -> push accepted, Count stays 64, and ID 33 is routed last.
- Initialize during ROUTE -> ignored.
- Initialize in IDLE with 4 entries -> Count=0 next cycle, NeuronID=0.
